// File: rtl/freq_scan_ctrl_pkg.sv
// freq_scan_ctrl shared types and constants.
// State encoding, channel-width helper, saturation value.
package freq_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_GATE    = 3'd3,
    ST_PRESENT = 3'd4
  } state_t;

  localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/freq_scan_ctrl_if.sv
// Result handshake bundle of freq_scan_ctrl.
// master = producer of results, slave = consumer.
interface freq_scan_ctrl_if
  import freq_scan_ctrl_pkg::*;
#(
  parameter int N_CH = 4
);
  localparam int CH_W = ch_w(N_CH);

  logic [31:0]     result;
  logic [CH_W-1:0] result_ch;
  logic            result_valid;
  logic            result_ready;
  logic            result_sat;

  modport master (
    output result, result_ch, result_valid, result_sat,
    input  result_ready
  );

  modport slave (
    input  result, result_ch, result_valid, result_sat,
    output result_ready
  );
endinterface

// File: rtl/freq_gate_core.sv
// Synchronizer, rising-edge detect, saturating counter.
// o_count/o_sat include this cycle's edge for latching.
module freq_gate_core
  import freq_scan_ctrl_pkg::*;
#(
  parameter logic [31:0] CLR_VAL = '0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sig,
  input  logic        i_clr,
  input  logic        i_count_en,
  output logic [31:0] o_count,
  output logic        o_sat
);

  // [0]=sync ff1, [1]=sync ff2, [2]=prev for edge detect
  logic [2:0]  sync_q, sync_d;
  logic [31:0] cnt_q, cnt_d;
  logic        sat_q, sat_d;
  logic        rise;

  // Registers: synchronizer chain and counter state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  // Next state: shift the chain, count edges, clamp at max
  always_comb begin
    sync_d = {sync_q[1:0], i_sig};
    rise   = sync_q[1] & ~sync_q[2];
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    if (i_clr) begin
      cnt_d = CLR_VAL;
      sat_d = 1'b0;
    end else if (i_count_en && rise) begin
      if (cnt_q == SAT_MAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  assign o_count = cnt_d;
  assign o_sat   = sat_d;

endmodule

// File: rtl/freq_scan_ctrl.sv
// Round-robin gated frequency measurement controller.
// One shared edge counter, results on valid/ready.
module freq_scan_ctrl
  import freq_scan_ctrl_pkg::*;
#(
  parameter int          N_CH          = 4,
  parameter int          GATE_CYCLES   = 25_000_000,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [31:0] CNT_PRELOAD   = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_freq_in,
  input  logic [N_CH-1:0] i_ch_enable,
  input  logic            i_start,
  input  logic            i_continuous,
  output logic            o_busy,
  freq_scan_ctrl_if.master res
);

  localparam int CH_W = ch_w(N_CH);
  localparam int SW   = $clog2(SETTLE_CYCLES);
  localparam int GW   = (GATE_CYCLES > 1) ?
                        $clog2(GATE_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] sel_q, sel_d;
  logic            last_q, last_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [GW-1:0]   gate_q, gate_d;
  logic [31:0]     result_q, result_d;
  logic [CH_W-1:0] rch_q, rch_d;
  logic            rsat_q, rsat_d;

  logic [CH_W-1:0] pick;
  logic [CH_W-1:0] top_en;
  logic            hit;
  logic            clr;
  logic            cnt_en;
  logic [31:0]     core_cnt;
  logic            core_sat;

  function automatic logic [CH_W-1:0] wrap_add(
    input logic [CH_W-1:0] a,
    input int              b
  );
    int s;
    s = int'(a) + b;
    if (s >= N_CH) s = s - N_CH;
    return CH_W'(s);
  endfunction

  freq_gate_core #(
    .CLR_VAL (CNT_PRELOAD)
  ) u_core (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sig      (i_freq_in[sel_q]),
    .i_clr      (clr),
    .i_count_en (cnt_en),
    .o_count    (core_cnt),
    .o_sat      (core_sat)
  );

  // Channel search: first enabled at/after ptr, and the top one
  always_comb begin
    pick   = '0;
    hit    = 1'b0;
    top_en = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_ch_enable[wrap_add(ptr_q, i)]) begin
        pick = wrap_add(ptr_q, i);
        hit  = 1'b1;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (i_ch_enable[i]) top_en = CH_W'(i);
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      last_q   <= 1'b0;
      settle_q <= '0;
      gate_q   <= '0;
      result_q <= '0;
      rch_q    <= '0;
      rsat_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      result_q <= result_d;
      rch_q    <= rch_d;
      rsat_q   <= rsat_d;
    end
  end

  // Scan FSM: next state, timers, pointer, result capture
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    last_d   = last_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    result_d = result_q;
    rch_d    = rch_q;
    rsat_d   = rsat_q;
    clr      = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if ((i_start || i_continuous) && |i_ch_enable) begin
          ptr_d   = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        clr = 1'b1;
        if (hit) begin
          sel_d    = pick;
          last_d   = (pick == top_en);
          settle_d = SW'(SETTLE_CYCLES - 1);
          state_d  = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          gate_d  = GW'(GATE_CYCLES - 1);
          state_d = ST_GATE;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      ST_GATE: begin
        cnt_en = 1'b1;
        if (gate_q == '0) begin
          result_d = core_cnt;
          rsat_d   = core_sat;
          rch_d    = sel_q;
          state_d  = ST_PRESENT;
        end else begin
          gate_d = gate_q - GW'(1);
        end
      end
      ST_PRESENT: begin
        if (res.result_ready) begin
          ptr_d = wrap_add(sel_q, 1);
          if (!last_q || i_continuous) begin
            state_d = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy           = (state_q != ST_IDLE);
  assign res.result_valid = (state_q == ST_PRESENT);
  assign res.result       = result_q;
  assign res.result_ch    = rch_q;
  assign res.result_sat   = rsat_q;

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Self-checking bench for freq_scan_ctrl.
// Synthetic square waves, expected counts from period math.
module tb_freq_scan_ctrl;

  localparam int N = 4;
  localparam int G = 100;
  localparam int S = 4;
  localparam int BUDGET = 2 * (G + S) + 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] freq_in = '0;
  logic [N-1:0] mask = '0;
  logic         start = 1'b0;
  logic         cont = 1'b0;
  logic         busy;
  logic [N-1:0] mask2 = 4'b0001;
  logic         start2 = 1'b0;
  logic         busy2;

  int   per [N];
  int   ofs [N];
  logic lvl [N];
  int   cyc = 0;
  int   n_err = 0;
  int   n_chk = 0;
  int   divs [8] = '{2, 4, 5, 10, 20, 25, 50, 100};

  freq_scan_ctrl_if #(.N_CH(N)) bus ();
  freq_scan_ctrl_if #(.N_CH(N)) bus2 ();

  freq_scan_ctrl #(
    .N_CH          (N),
    .GATE_CYCLES   (G),
    .SETTLE_CYCLES (S)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_freq_in    (freq_in),
    .i_ch_enable  (mask),
    .i_start      (start),
    .i_continuous (cont),
    .o_busy       (busy),
    .res          (bus)
  );

  freq_scan_ctrl #(
    .N_CH          (N),
    .GATE_CYCLES   (G),
    .SETTLE_CYCLES (S),
    .CNT_PRELOAD   (32'hFFFF_FFFE)
  ) dut_sat (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_freq_in    (freq_in),
    .i_ch_enable  (mask2),
    .i_start      (start2),
    .i_continuous (1'b0),
    .o_busy       (busy2),
    .res          (bus2)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Square-wave generator: one rise per period, per[c]==0 holds lvl
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < N; c++) begin
        if (per[c] == 0) freq_in[c] = lvl[c];
        else freq_in[c] = ((cyc + ofs[c]) % per[c]) < (per[c] / 2);
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_cnt(input int c);
    return (per[c] == 0) ? 0 : G / per[c];
  endfunction

  task automatic wait_valid(output int n, output bit ok);
    n = 0;
    while (!bus.result_valid && n < BUDGET) begin
      tick();
      n++;
    end
    ok = bus.result_valid;
    if (!ok) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_pass(input logic [3:0] m,
                          input int stall,
                          output int lat);
    int n;
    bit ok;
    bit first;
    bit stable;
    logic [31:0] r0;
    logic [1:0]  c0;
    mask = m;
    first = 1'b1;
    lat = 0;
    bus.result_ready = (stall == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (m[c]) begin
        wait_valid(n, ok);
        if (first) lat = n + 1;
        first = 1'b0;
        if (ok) begin
          chk("ch", 32'(bus.result_ch), 32'(c));
          chk("cnt", bus.result, 32'(exp_cnt(c)));
          chk("sat", 32'(bus.result_sat), 32'd0);
          if (stall > 0) begin
            r0 = bus.result;
            c0 = bus.result_ch;
            stable = 1'b1;
            repeat (stall) begin
              tick();
              if (!bus.result_valid || !busy ||
                  bus.result !== r0 ||
                  bus.result_ch !== c0) stable = 1'b0;
            end
            chk("stall_hold", 32'(stable), 32'd1);
            bus.result_ready = 1'b1;
            tick();
            bus.result_ready = 1'b0;
          end else begin
            tick();
          end
          chk("vdrop", 32'(bus.result_valid), 32'd0);
        end
      end
    end
    chk("pass_end_idle", 32'(busy), 32'd0);
    bus.result_ready = 1'b1;
  endtask

  initial begin
    int lat;
    int n;
    int k;
    bit ok;
    logic [3:0] m;
    longint t;
    for (int c = 0; c < N; c++) begin
      ofs[c] = $urandom_range(0, 99);
      lvl[c] = 1'b0;
    end
    per[0] = 10; per[1] = 20; per[2] = 25; per[3] = 50;
    bus.result_ready = 1'b1;
    bus2.result_ready = 1'b1;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_ch", 32'(bus.result_ch), 32'd0);
    chk("rst_sat", 32'(bus.result_sat), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Full mask, fixed periods, ready tied high
    run_pass(4'b1111, 0, lat);
    chk("first_latency", 32'(lat), 32'd106);

    // Quiet channel to leave the synchronizer low, then 1010
    per[0] = 0; lvl[0] = 1'b0;
    run_pass(4'b0001, 0, lat);
    per[1] = 0; lvl[1] = 1'b1;
    per[3] = 5;
    run_pass(4'b1010, 0, lat);

    // Back-pressure for 50 cycles on each result
    per[1] = 20; per[3] = 50;
    run_pass(4'b0110, 50, lat);

    // Continuous scanning on one channel
    mask = 4'b0001;
    per[0] = 10;
    bus.result_ready = 1'b1;
    cont = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(n, ok);
      chk("cont_ch", 32'(bus.result_ch), 32'd0);
      chk("cont_cnt", bus.result, 32'd10);
      tick();
      chk("cont_no_idle", 32'(busy), 32'd1);
      chk("cont_vdrop", 32'(bus.result_valid), 32'd0);
    end
    cont = 1'b0;
    wait_valid(n, ok);
    chk("cont_last_cnt", bus.result, 32'd10);
    tick();
    chk("cont_end_idle", 32'(busy), 32'd0);
    n = 0;
    repeat (2 * (G + S)) begin
      tick();
      if (bus.result_valid || busy) n++;
    end
    chk("cont_no_extra", 32'(n), 32'd0);

    // Empty mask: start dropped
    mask = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    repeat (20) begin
      if (busy || bus.result_valid) n++;
      tick();
    end
    chk("mask0_idle", 32'(n), 32'd0);

    // Reset in the middle of a gate on ch2
    mask = 4'b0100;
    per[2] = 10;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 + S + 30) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(bus.result_valid), 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_ch", 32'(bus.result_ch), 32'd0);
    chk("mid_rst_sat", 32'(bus.result_sat), 32'd0);
    rst = 1'b0;
    tick();
    per[0] = 10; per[1] = 20; per[2] = 25; per[3] = 50;
    run_pass(4'b1111, 0, lat);

    // Randomized masks, periods, levels and stalls
    for (int it = 0; it < 6; it++) begin
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < N; c++) begin
        k = $urandom_range(0, 9);
        if (k < 8) per[c] = divs[k];
        else begin
          per[c] = 0;
          lvl[c] = 1'(k & 1);
        end
        ofs[c] = $urandom_range(0, 99);
      end
      k = $urandom_range(0, 1);
      run_pass(m, (k == 1) ? $urandom_range(1, 20) : 0, lat);
    end

    // Saturation from a preloaded counter
    for (int i = 0; i < 2; i++) begin
      per[0] = (i == 0) ? 50 : 25;
      ofs[0] = $urandom_range(0, 99);
      t = 64'hFFFF_FFFE + longint'(G / per[0]);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      n = 0;
      while (!bus2.result_valid && n < BUDGET) begin
        tick();
        n++;
      end
      chk("sat_valid", 32'(bus2.result_valid), 32'd1);
      chk("sat_cnt", bus2.result,
          (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(t));
      chk("sat_flag", 32'(bus2.result_sat),
          (t > 64'hFFFF_FFFF) ? 32'd1 : 32'd0);
      tick();
      chk("sat_end_idle", 32'(busy2), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
